// File: rtl/hash_pkg.sv
// Shared types and constants for the byte-hash sequencer and its round counter.
package hash_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    WAIT_BYTE,
    ROUND,
    FINAL,
    DONE
  } hash_seq_state_e;

  localparam logic [31:0] HASH_IV              = 32'h3FA1EF23;
  localparam int          ROUND_IDX_W          = 3;
  localparam int          DEFAULT_ROUNDS       = 8;
  localparam int          DEFAULT_FINAL_ROUNDS = 8;

  // Terminal round index for a round count in 1..8.
  function automatic logic [ROUND_IDX_W-1:0] lastRoundIdx(input int rounds);
    return ROUND_IDX_W'(rounds - 1);
  endfunction

endpackage

// File: rtl/hash_sequencer_if.sv
// Byte-stream handshake plus the control/status wires to the hash datapath.
interface hash_sequencer_if;
  import hash_pkg::*;

  logic                   in_valid;
  logic [7:0]             in_data;
  logic                   in_last;
  logic                   in_ready;
  logic [7:0]             dp_B;
  logic                   dp_start;
  logic                   dp_validate_input;
  logic                   dp_switch_operation;
  logic                   dp_validate_R_h;
  logic [ROUND_IDX_W-1:0] dp_R_i;
  logic                   dp_case_R_c_zero;

  // The sequencer side: consumes the byte stream, drives the datapath.
  modport slave (
    input  in_valid, in_data, in_last, dp_case_R_c_zero,
    output in_ready, dp_B, dp_start, dp_validate_input,
           dp_switch_operation, dp_validate_R_h, dp_R_i
  );

  // The environment side: message source plus datapath.
  modport master (
    output in_valid, in_data, in_last, dp_case_R_c_zero,
    input  in_ready, dp_B, dp_start, dp_validate_input,
           dp_switch_operation, dp_validate_R_h, dp_R_i
  );

endinterface

// File: rtl/hash_round_counter.sv
// Round index counter with clear/enable; terminal count depends on message vs finalisation phase.
module hash_round_counter
  import hash_pkg::*;
#(
  parameter int ROUNDS       = DEFAULT_ROUNDS,
  parameter int FINAL_ROUNDS = DEFAULT_FINAL_ROUNDS
) (
  input  logic                   clock,
  input  logic                   rstn,
  input  logic                   clear_i,
  input  logic                   enable_i,
  input  logic                   finalPhase_i,
  output logic [ROUND_IDX_W-1:0] count_o,
  output logic                   terminal_o
);

  localparam logic [ROUND_IDX_W-1:0] ROUND_LAST = lastRoundIdx(ROUNDS);
  localparam logic [ROUND_IDX_W-1:0] FINAL_LAST = lastRoundIdx(FINAL_ROUNDS);

  logic [ROUND_IDX_W-1:0] count_q;

  // Clear wins over enable so the FSM can restart the count on the terminal cycle.
  always_ff @(posedge clock or negedge rstn) begin
    if (!rstn) begin
      count_q <= '0;
    end else if (clear_i) begin
      count_q <= '0;
    end else if (enable_i) begin
      count_q <= count_q + ROUND_IDX_W'(1);
    end
  end

  assign count_o    = count_q;
  assign terminal_o = (count_q == (finalPhase_i ? FINAL_LAST : ROUND_LAST));

endmodule

// File: rtl/hash_sequencer.sv
// Control FSM for the 32-bit byte-hash datapath: byte intake, mixing rounds, length finalisation.
// Optional HASH_SEQ_PERF_EN adds perf_bytes/perf_cycles message counters.
module hash_sequencer
  import hash_pkg::*;
#(
  parameter int ROUNDS       = DEFAULT_ROUNDS,
  parameter int FINAL_ROUNDS = DEFAULT_FINAL_ROUNDS
) (
  input  logic             clock,
  input  logic             rstn,
  input  logic             start,
  hash_sequencer_if.slave  bus,
  output logic             busy,
  output logic             done,
  output logic             err_len
`ifdef HASH_SEQ_PERF_EN
  ,
  output logic [31:0]      perf_bytes,
  output logic [31:0]      perf_cycles
`endif
);

  hash_seq_state_e        state_q, state_d;
  logic                   lastByte_q, lastByte_d;
  logic                   errLen_q, errLen_d;
  logic                   roundClear, roundEnable, roundTerminal;
  logic [ROUND_IDX_W-1:0] roundCount;

  hash_round_counter #(
    .ROUNDS       (ROUNDS),
    .FINAL_ROUNDS (FINAL_ROUNDS)
  ) u_round_counter (
    .clock        (clock),
    .rstn         (rstn),
    .clear_i      (roundClear),
    .enable_i     (roundEnable),
    .finalPhase_i (state_q == FINAL),
    .count_o      (roundCount),
    .terminal_o   (roundTerminal)
  );

  always_ff @(posedge clock or negedge rstn) begin
    if (!rstn) begin
      state_q    <= IDLE;
      lastByte_q <= 1'b0;
      errLen_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      lastByte_q <= lastByte_d;
      errLen_q   <= errLen_d;
    end
  end

  always_comb begin
    state_d                 = state_q;
    lastByte_d              = lastByte_q;
    errLen_d                = errLen_q;
    roundClear              = 1'b0;
    roundEnable             = 1'b0;
    bus.in_ready            = 1'b0;
    bus.dp_B                = 8'h00;
    bus.dp_start            = 1'b0;
    bus.dp_validate_input   = 1'b0;
    bus.dp_switch_operation = 1'b0;
    bus.dp_validate_R_h     = 1'b0;
    bus.dp_R_i              = '0;
    done                    = 1'b0;
    busy                    = (state_q != IDLE);

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = CLEAR;
        end
      end
      CLEAR: begin
        bus.dp_start = 1'b1;
        errLen_d     = 1'b0;
        roundClear   = 1'b1;
        state_d      = WAIT_BYTE;
      end
      WAIT_BYTE: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) begin
          roundClear = 1'b1;
          // A saturated length counter cannot absorb another byte: drop it and finalise.
          if (bus.dp_case_R_c_zero) begin
            bus.dp_B              = bus.in_data;
            bus.dp_validate_input = 1'b1;
            lastByte_d            = bus.in_last;
            state_d               = ROUND;
          end else begin
            errLen_d = 1'b1;
            state_d  = FINAL;
          end
        end
      end
      ROUND: begin
        bus.dp_validate_R_h = 1'b1;
        bus.dp_R_i          = roundCount;
        roundEnable         = 1'b1;
        if (roundTerminal) begin
          roundClear = 1'b1;
          state_d    = lastByte_q ? FINAL : WAIT_BYTE;
        end
      end
      FINAL: begin
        bus.dp_validate_R_h     = 1'b1;
        bus.dp_switch_operation = 1'b1;
        bus.dp_R_i              = roundCount;
        roundEnable             = 1'b1;
        if (roundTerminal) begin
          roundClear = 1'b1;
          state_d    = DONE;
        end
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign err_len = errLen_q;

`ifdef HASH_SEQ_PERF_EN
  logic [31:0] perfBytes_q, perfCycles_q;

  // perf_cycles starts at 1 so the CLEAR cycle itself is included in the count.
  always_ff @(posedge clock or negedge rstn) begin
    if (!rstn) begin
      perfBytes_q  <= '0;
      perfCycles_q <= '0;
    end else if (state_q == CLEAR) begin
      perfBytes_q  <= '0;
      perfCycles_q <= 32'd1;
    end else begin
      if (bus.dp_validate_input && (perfBytes_q != '1)) begin
        perfBytes_q <= perfBytes_q + 32'd1;
      end
      if ((state_q != IDLE) && (perfCycles_q != '1)) begin
        perfCycles_q <= perfCycles_q + 32'd1;
      end
    end
  end

  assign perf_bytes  = perfBytes_q;
  assign perf_cycles = perfCycles_q;
`endif

endmodule

// File: tb/tb_hash_sequencer.sv
// Directed self-checking bench for hash_sequencer with a behavioural datapath stub.
module tb_hash_sequencer;
  import hash_pkg::*;

  localparam int ROUNDS       = 8;
  localparam int FINAL_ROUNDS = 8;

  logic clock = 1'b0;
  logic rstn  = 1'b0;
  logic start = 1'b0;
  logic busy, done, err_len;
  logic forceCaseZero = 1'b0;
  int   checks   = 0;
  int   failures = 0;

  hash_sequencer_if bus ();
  assign bus.dp_case_R_c_zero = ~forceCaseZero;

`ifdef HASH_SEQ_PERF_EN
  logic [31:0] perf_bytes, perf_cycles;
`endif

  hash_sequencer #(
    .ROUNDS       (ROUNDS),
    .FINAL_ROUNDS (FINAL_ROUNDS)
  ) dut (
    .clock   (clock),
    .rstn    (rstn),
    .start   (start),
    .bus     (bus.slave),
    .busy    (busy),
    .done    (done),
    .err_len (err_len)
`ifdef HASH_SEQ_PERF_EN
    ,
    .perf_bytes  (perf_bytes),
    .perf_cycles (perf_cycles)
`endif
  );

  always #5 clock = ~clock;

  // Datapath stub: R_h mixing driven purely by the sequencer's dp_* controls.
  function automatic logic [31:0] mix(input logic [31:0] h, input logic [31:0] v, input int r);
    logic [31:0] rot;
    rot = {h[26:0], h[31:27]};
    return (rot ^ (v * 32'h9E3779B1)) + 32'(r) + 32'd1;
  endfunction

  logic [31:0] stubRh = '0;
  logic [31:0] stubRc = '0;
  logic [7:0]  stubRb = '0;

  always @(posedge clock) begin
    if (bus.dp_start) begin
      stubRh <= HASH_IV;
      stubRc <= '0;
      stubRb <= '0;
    end else begin
      if (bus.dp_validate_input) begin
        stubRb <= bus.dp_B;
        stubRc <= stubRc + 32'd1;
      end
      if (bus.dp_validate_R_h) begin
        stubRh <= mix(stubRh, bus.dp_switch_operation ? stubRc : {24'd0, stubRb}, int'(bus.dp_R_i));
      end
    end
  end

  // Expected digest for the bytes the datapath should have loaded.
  logic [7:0] expQ[$];

  function automatic logic [31:0] refDigest();
    logic [31:0] h;
    h = HASH_IV;
    foreach (expQ[i]) begin
      for (int r = 0; r < ROUNDS; r++) h = mix(h, {24'd0, expQ[i]}, r);
    end
    for (int r = 0; r < FINAL_ROUNDS; r++) h = mix(h, 32'(expQ.size()), r);
    return h;
  endfunction

  // Event log, sampled on the falling edge.
  int         cyc = 0;
  logic [7:0] loadQ[$];
  int         loadCyc[$];
  int         riQ[$];
  int         finQ[$];
  int         startCyc = -1, doneCyc = -1;
  int         startCnt = 0, doneCnt = 0, overlapCnt = 0;

  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock) begin
    if (bus.dp_validate_input) begin
      loadQ.push_back(bus.dp_B);
      loadCyc.push_back(cyc);
    end
    if (bus.dp_validate_R_h && !bus.dp_switch_operation) riQ.push_back(int'(bus.dp_R_i));
    if (bus.dp_validate_R_h && bus.dp_switch_operation) finQ.push_back(int'(bus.dp_R_i));
    if (bus.dp_start) begin
      startCnt++;
      startCyc = cyc;
    end
    if (done) begin
      doneCnt++;
      doneCyc = cyc;
    end
    if (bus.dp_validate_input && bus.dp_validate_R_h) overlapCnt++;
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic clearLogs();
    loadQ.delete();
    loadCyc.delete();
    riQ.delete();
    finQ.delete();
    expQ.delete();
    startCnt = 0;
    doneCnt  = 0;
    startCyc = -1;
    doneCyc  = -1;
  endtask

  task automatic pulseStart();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  // Presents a byte and holds it until the handshake; in_valid is left high for the caller.
  task automatic applyStimulus(input logic [7:0] data, input logic last, output int accCyc);
    bit got;
    got    = 1'b0;
    accCyc = -1;
    bus.in_valid = 1'b1;
    bus.in_data  = data;
    bus.in_last  = last;
    for (int i = 0; i < 64 && !got; i++) begin
      @(negedge clock);
      if (bus.in_ready) begin
        got    = 1'b1;
        accCyc = cyc;
      end
      step();
    end
    checks++;
    if (!got) begin
      failures++;
      $display("[TB] FAIL accept_timeout got=none want=handshake data=%0h", data);
    end
  endtask

  task automatic waitDone(input int maxCyc);
    bit got;
    got = 1'b0;
    for (int i = 0; i < maxCyc && !got; i++) begin
      @(negedge clock);
      if (done) got = 1'b1;
      step();
    end
    checks++;
    if (!got) begin
      failures++;
      $display("[TB] FAIL done_timeout got=0 want=1");
    end
  endtask

  task automatic test_reset();
    logic [21:0] outs;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    bus.in_last  = 1'b0;
    rstn = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    outs = {bus.in_ready, bus.dp_B, bus.dp_start, bus.dp_validate_input, bus.dp_switch_operation,
            bus.dp_validate_R_h, bus.dp_R_i, busy, done, err_len, 3'b000};
    checks++;
    if (outs !== 22'd0) begin
      failures++;
      $display("[TB] FAIL reset_outputs got=%0h want=0", outs);
    end
    #2 rstn = 1'b1;
    step();
    bus.in_valid = 1'b1;
    bus.in_data  = 8'hEE;
    repeat (3) step();
    @(negedge clock);
    checks++;
    if ({bus.in_ready, busy, bus.dp_validate_input} !== 3'b000) begin
      failures++;
      $display("[TB] FAIL idle_ignores_valid got=%0b want=000", {bus.in_ready, busy, bus.dp_validate_input});
    end
    step();
    bus.in_valid = 1'b0;
  endtask

  task automatic test_single_byte();
    int a, bad;
    clearLogs();
    pulseStart();
    applyStimulus(8'hA5, 1'b1, a);
    bus.in_valid = 1'b0;
    waitDone(40);
    expQ.push_back(8'hA5);
    checks++;
    if (loadQ.size() !== 1 || loadQ[0] !== 8'hA5) begin
      failures++;
      $display("[TB] FAIL single_load got=n%0d b%0h want=n1 ba5", loadQ.size(), loadQ[0]);
    end
    checks++;
    if (a - startCyc !== 1) begin
      failures++;
      $display("[TB] FAIL clear_to_accept got=%0d want=1", a - startCyc);
    end
    checks++;
    if (doneCyc - startCyc !== 18) begin
      failures++;
      $display("[TB] FAIL start_to_done got=%0d want=18", doneCyc - startCyc);
    end
    bad = 0;
    foreach (riQ[i]) if (riQ[i] !== i % ROUNDS) bad++;
    foreach (finQ[i]) if (finQ[i] !== i % FINAL_ROUNDS) bad++;
    checks++;
    if (riQ.size() !== ROUNDS || finQ.size() !== FINAL_ROUNDS || bad !== 0) begin
      failures++;
      $display("[TB] FAIL round_indices got=r%0d f%0d bad%0d want=r8 f8 bad0", riQ.size(), finQ.size(), bad);
    end
    checks++;
    if (stubRh !== refDigest()) begin
      failures++;
      $display("[TB] FAIL single_digest got=%h want=%h", stubRh, refDigest());
    end
    checks++;
    if ({busy, err_len, done} !== 3'b000 || doneCnt !== 1) begin
      failures++;
      $display("[TB] FAIL single_idle got=%0b d%0d want=000 d1", {busy, err_len, done}, doneCnt);
    end
  endtask

  task automatic test_back_to_back();
    int a0, a1, a2, bad;
    clearLogs();
    pulseStart();
    applyStimulus(8'h11, 1'b0, a0);
    applyStimulus(8'h22, 1'b0, a1);
    applyStimulus(8'h33, 1'b1, a2);
    bus.in_valid = 1'b0;
    waitDone(40);
    expQ = '{8'h11, 8'h22, 8'h33};
    checks++;
    if (loadQ.size() !== 3 || loadQ[0] !== 8'h11 || loadQ[1] !== 8'h22 || loadQ[2] !== 8'h33) begin
      failures++;
      $display("[TB] FAIL b2b_loads got=n%0d want=n3 11,22,33", loadQ.size());
    end
    checks++;
    if (a1 - a0 !== 1 + ROUNDS || a2 - a1 !== 1 + ROUNDS) begin
      failures++;
      $display("[TB] FAIL b2b_spacing got=%0d,%0d want=9,9", a1 - a0, a2 - a1);
    end
    bad = 0;
    foreach (riQ[i]) if (riQ[i] !== i % ROUNDS) bad++;
    checks++;
    if (riQ.size() !== 3 * ROUNDS || bad !== 0) begin
      failures++;
      $display("[TB] FAIL b2b_round_idx got=n%0d bad%0d want=n24 bad0", riQ.size(), bad);
    end
    checks++;
    if (doneCyc - a2 !== ROUNDS + FINAL_ROUNDS + 1) begin
      failures++;
      $display("[TB] FAIL last_to_done got=%0d want=17", doneCyc - a2);
    end
    checks++;
    if (stubRh !== refDigest()) begin
      failures++;
      $display("[TB] FAIL b2b_digest got=%h want=%h", stubRh, refDigest());
    end
  endtask

  task automatic test_random_valid();
    logic [7:0] msg[5];
    int a, bad;
    msg = '{8'h00, 8'hFF, 8'h5A, 8'hC3, 8'h81};
    clearLogs();
    pulseStart();
    for (int i = 0; i < 5; i++) begin
      bus.in_valid = 1'b0;
      repeat ($urandom_range(0, 3)) begin
        bus.in_data = 8'($urandom);
        step();
      end
      applyStimulus(msg[i], i == 4, a);
      expQ.push_back(msg[i]);
    end
    bus.in_valid = 1'b0;
    waitDone(60);
    bad = 0;
    foreach (loadQ[i]) if (loadQ[i] !== msg[i]) bad++;
    checks++;
    if (loadQ.size() !== 5 || bad !== 0) begin
      failures++;
      $display("[TB] FAIL random_loads got=n%0d bad%0d want=n5 bad0", loadQ.size(), bad);
    end
    checks++;
    if (stubRh !== refDigest()) begin
      failures++;
      $display("[TB] FAIL random_digest got=%h want=%h", stubRh, refDigest());
    end
  endtask

  task automatic test_len_error();
    int a0, a1, a2;
    clearLogs();
    pulseStart();
    applyStimulus(8'h10, 1'b0, a0);
    forceCaseZero = 1'b1;
    applyStimulus(8'h20, 1'b0, a1);
    forceCaseZero = 1'b0;
    bus.in_valid  = 1'b0;
    waitDone(40);
    expQ.push_back(8'h10);
    checks++;
    if (loadQ.size() !== 1 || loadQ[0] !== 8'h10) begin
      failures++;
      $display("[TB] FAIL drop_no_load got=n%0d want=n1", loadQ.size());
    end
    checks++;
    if (doneCyc - a1 !== FINAL_ROUNDS + 1 || finQ.size() !== FINAL_ROUNDS) begin
      failures++;
      $display("[TB] FAIL drop_final got=%0d f%0d want=9 f8", doneCyc - a1, finQ.size());
    end
    checks++;
    if (stubRh !== refDigest()) begin
      failures++;
      $display("[TB] FAIL drop_digest got=%h want=%h", stubRh, refDigest());
    end
    repeat (3) step();
    checks++;
    if (err_len !== 1'b1) begin
      failures++;
      $display("[TB] FAIL err_len_sticky got=%0b want=1", err_len);
    end
    pulseStart();
    step();
    checks++;
    if (err_len !== 1'b0) begin
      failures++;
      $display("[TB] FAIL err_len_cleared got=%0b want=0", err_len);
    end
    applyStimulus(8'h77, 1'b1, a2);
    bus.in_valid = 1'b0;
    waitDone(40);
  endtask

  task automatic test_reset_mid();
    int a;
    bit hit;
    logic [19:0] outs;
    clearLogs();
    pulseStart();
    applyStimulus(8'h42, 1'b1, a);
    bus.in_valid = 1'b0;
    hit = 1'b0;
    for (int i = 0; i < 40 && !hit; i++) begin
      @(negedge clock);
      if (bus.dp_validate_R_h && !bus.dp_switch_operation && bus.dp_R_i == 3'd4) hit = 1'b1;
    end
    checks++;
    if (!hit) begin
      failures++;
      $display("[TB] FAIL round4_timeout got=0 want=1");
    end
    #1 rstn = 1'b0;
    @(negedge clock);
    outs = {bus.in_ready, bus.dp_B, bus.dp_start, bus.dp_validate_input, bus.dp_switch_operation,
            bus.dp_validate_R_h, bus.dp_R_i, busy, done, err_len};
    checks++;
    if (outs !== 20'd0) begin
      failures++;
      $display("[TB] FAIL midreset_outputs got=%0h want=0", outs);
    end
    @(negedge clock);
    #1 rstn = 1'b1;
    repeat (30) step();
    checks++;
    if (doneCnt !== 0 || busy !== 1'b0) begin
      failures++;
      $display("[TB] FAIL midreset_no_done got=d%0d b%0b want=d0 b0", doneCnt, busy);
    end
    clearLogs();
    pulseStart();
    applyStimulus(8'h99, 1'b1, a);
    bus.in_valid = 1'b0;
    waitDone(40);
    expQ.push_back(8'h99);
    checks++;
    if (stubRh !== refDigest() || loadQ.size() !== 1) begin
      failures++;
      $display("[TB] FAIL restart_digest got=%h want=%h", stubRh, refDigest());
    end
  endtask

  task automatic test_start_ignored();
    int a;
    clearLogs();
    start        = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h3C;
    bus.in_last  = 1'b1;
    @(negedge clock);
    checks++;
    if ({bus.in_ready, bus.dp_validate_input} !== 2'b00) begin
      failures++;
      $display("[TB] FAIL start_wins_idle got=%0b want=00", {bus.in_ready, bus.dp_validate_input});
    end
    step();
    start = 1'b0;
    applyStimulus(8'h3C, 1'b1, a);
    bus.in_valid = 1'b0;
    repeat (2) step();
    pulseStart();
    waitDone(40);
    checks++;
    if (a - startCyc !== 1 || loadQ.size() !== 1 || loadQ[0] !== 8'h3C) begin
      failures++;
      $display("[TB] FAIL byte_in_wait got=%0d n%0d want=1 n1", a - startCyc, loadQ.size());
    end
    checks++;
    if (startCnt !== 1 || doneCnt !== 1 || doneCyc - a !== ROUNDS + FINAL_ROUNDS + 1) begin
      failures++;
      $display("[TB] FAIL start_in_round got=s%0d d%0d t%0d want=s1 d1 t17", startCnt, doneCnt, doneCyc - a);
    end
    checks++;
    if (overlapCnt !== 0) begin
      failures++;
      $display("[TB] FAIL validate_overlap got=%0d want=0", overlapCnt);
    end
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog got=timeout want=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_single_byte();
    test_back_to_back();
    test_random_valid();
    test_len_error();
    test_reset_mid();
    test_start_ignored();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
